// File: rtl/mem_ctl_mem_responder.sv
// Memory-side responder for the mem_write/mem_read/mem_done four-phase handshake.
// The request lines are synchronised into clk. After a fixed access latency the
// responder writes or reads an internal register-file array. It then holds
// mem_done high until the request is withdrawn. Controller-side protocol
// violations raise a sticky proto_err flag.
module mem_ctl_mem_responder #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int LATENCY     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] rdata,
  output logic              proto_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] wr_sync_r;
  logic [SYNC_STAGES-1:0] rd_sync_r;
  logic                   wr_s;
  logic                   rd_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   op_wr_r;       // latched operation: 1 = write, 0 = read
  logic                   op_wr_nxt_s;
  logic [ADDR_W-1:0]      addr_r;
  logic [ADDR_W-1:0]      addr_nxt_s;
  logic [DATA_W-1:0]      wdata_r;
  logic [DATA_W-1:0]      wdata_nxt_s;
  logic                   done_nxt_s;
  logic [DATA_W-1:0]      rdata_nxt_s;
  logic                   perr_nxt_s;
  logic                   arr_we_s;
  logic                   req_lat_s;
  logic                   other_s;

  logic [DATA_W-1:0]      mem_r [DEPTH];

  // Request synchroniser: shift the asynchronous request levels into clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sync_r <= {SYNC_STAGES{1'b0}};
      rd_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      wr_sync_r <= {wr_sync_r[SYNC_STAGES-2:0], mem_write};
      rd_sync_r <= {rd_sync_r[SYNC_STAGES-2:0], mem_read};
    end
  end

  assign wr_s      = wr_sync_r[SYNC_STAGES-1];
  assign rd_s      = rd_sync_r[SYNC_STAGES-1];
  // The request that started the access, and the one that must stay quiet.
  assign req_lat_s = op_wr_r ? wr_s : rd_s;
  assign other_s   = op_wr_r ? rd_s : wr_s;

  // State register plus the registered outputs and the latched request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_wr_r   <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      mem_done  <= 1'b0;
      rdata     <= {DATA_W{1'b0}};
      proto_err <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      op_wr_r   <= op_wr_nxt_s;
      addr_r    <= addr_nxt_s;
      wdata_r   <= wdata_nxt_s;
      mem_done  <= done_nxt_s;
      rdata     <= rdata_nxt_s;
      proto_err <= perr_nxt_s;
    end
  end

  // Next-state logic of the handshake FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_s ^ rd_s)      state_nxt_s = ST_BUSY;
        else if (wr_s & rd_s) state_nxt_s = ST_HOLD;
        else                  state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (!req_lat_s)                    state_nxt_s = ST_IDLE;
        else if (cnt_r == CNT_W'(0))       state_nxt_s = ST_DONE;
        else                               state_nxt_s = ST_BUSY;
      end
      ST_DONE: begin
        if (!req_lat_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_DONE;
      end
      ST_HOLD: begin
        if (!wr_s && !rd_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; the array is written only on the completing edge.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    op_wr_nxt_s = op_wr_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    done_nxt_s  = mem_done;
    rdata_nxt_s = rdata;
    perr_nxt_s  = proto_err;
    arr_we_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        done_nxt_s = 1'b0;
        if (wr_s ^ rd_s) begin
          op_wr_nxt_s = wr_s;
          addr_nxt_s  = addr;
          wdata_nxt_s = wdata;
          cnt_nxt_s   = CNT_W'(LATENCY - 1);
        end else if (wr_s & rd_s) begin
          perr_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_BUSY: begin
        if (!req_lat_s) begin
          perr_nxt_s = 1'b1;
        end else begin
          if (other_s) begin
            perr_nxt_s = 1'b1;
          end else begin
            perr_nxt_s = proto_err;
          end
          if (cnt_r == CNT_W'(0)) begin
            done_nxt_s = 1'b1;
            if (op_wr_r) begin
              arr_we_s = 1'b1;
            end else begin
              rdata_nxt_s = mem_r[addr_r];
            end
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (other_s) begin
          perr_nxt_s = 1'b1;
        end else begin
          perr_nxt_s = proto_err;
        end
        if (!req_lat_s) begin
          done_nxt_s = 1'b0;
        end else begin
          done_nxt_s = 1'b1;
        end
      end
      ST_HOLD: begin
        done_nxt_s = 1'b0;
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Register-file array: cleared on reset, written on the completing edge of a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (arr_we_s) begin
      mem_r[addr_r] <= wdata_r;
    end else begin
      mem_r[addr_r] <= mem_r[addr_r];
    end
  end

endmodule

// File: tb/tb_mem_ctl_mem_responder.sv
// Self-checking bench for mem_ctl_mem_responder. Four instances with LATENCY 2, 4, 1 and 3
// share the clock and reset. A queue holds the expected read data. Each read pushes its
// expected value when the stimulus is driven. That value is popped and compared when
// mem_done rises.
module tb_mem_ctl_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] wr_v;
  logic [3:0] rd_v;
  logic [3:0] done_v;
  logic [3:0] perr_v;
  logic [3:0] addr_v  [4];
  logic [7:0] wdata_v [4];
  logic [7:0] rdata_v [4];

  logic [7:0] model [4][16];
  logic [7:0] exp_q [$];
  int         passed = 0;
  int         total  = 0;

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 3;
      mem_ctl_mem_responder #(
        .ADDR_W(4), .DATA_W(8), .LATENCY(LAT), .SYNC_STAGES(2)
      ) u_dut (
        .clk(clk), .rst(rst),
        .mem_write(wr_v[g]), .mem_read(rd_v[g]),
        .addr(addr_v[g]), .wdata(wdata_v[g]),
        .mem_done(done_v[g]), .rdata(rdata_v[g]), .proto_err(perr_v[g])
      );
    end
  endgenerate

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One full four-phase cycle with rise/fall latency checks and a scoreboard pop on reads.
  task automatic access(input int d, input bit is_wr, input logic [3:0] a,
                        input logic [7:0] wd, input int lat);
    int n;
    logic [7:0] exp;
    @(posedge clk); #1;
    addr_v[d]  = a;
    wdata_v[d] = wd;
    if (is_wr) begin
      wr_v[d] = 1'b1;
      model[d][a] = wd;
    end else begin
      rd_v[d] = 1'b1;
    end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done_v[d]) begin n = i; break; end
    end
    check($sformatf("rise_latency d%0d a%0d", d, a), n, 3 + lat);
    if (!is_wr) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("rdata d%0d a%0d", d, a), int'(rdata_v[d]), int'(exp));
      end
    end
    wr_v[d] = 1'b0;
    rd_v[d] = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!done_v[d]) begin n = i; break; end
    end
    check($sformatf("fall_latency d%0d a%0d", d, a), n, 3);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 4; d++)
      for (int a = 0; a < 16; a++)
        model[d][a] = 8'h00;
  endtask

  initial begin
    bit         seen;
    logic [7:0] rnd;

    vecs[0] = '{1'b1, 4'd3, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 4'd3, 8'h00, 8'hA5};
    vecs[2] = '{1'b0, 4'd4, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 4'd9, 8'h5A, 8'h00};
    vecs[4] = '{1'b0, 4'd9, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 4'd3, 8'h00, 8'hA5};

    rst  = 1'b0;
    wr_v = 4'h0;
    rd_v = 4'h0;
    for (int d = 0; d < 4; d++) begin
      addr_v[d]  = 4'h0;
      wdata_v[d] = 8'h00;
    end
    clear_model();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", int'(done_v[0]), 0);
    check("reset_rdata", int'(rdata_v[0]), 0);
    check("reset_perr", int'(perr_v[0]), 0);
    rst = 1'b1;

    // Write/read table on the LATENCY=2 instance.
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].is_wr) exp_q.push_back(vecs[i].exp_rdata);
      access(0, vecs[i].is_wr, vecs[i].addr, vecs[i].data, 2);
    end
    check("table_perr", int'(perr_v[0]), 0);

    // Both requests together from IDLE.
    @(posedge clk); #1;
    addr_v[0]  = 4'd5;
    wdata_v[0] = 8'hEE;
    wr_v[0]    = 1'b1;
    rd_v[0]    = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_v[0]) seen = 1'b1;
    end
    check("both_perr", int'(perr_v[0]), 1);
    check("both_no_done", int'(seen), 0);
    wr_v[0] = 1'b0;
    rd_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    access(0, 1'b1, 4'd6, 8'h42, 2);
    exp_q.push_back(8'h00);
    access(0, 1'b0, 4'd5, 8'h00, 2);
    exp_q.push_back(8'h42);
    access(0, 1'b0, 4'd6, 8'h00, 2);
    exp_q.push_back(8'hA5);
    access(0, 1'b0, 4'd3, 8'h00, 2);

    // Request withdrawn mid-BUSY on the LATENCY=4 instance.
    @(posedge clk); #1;
    addr_v[1]  = 4'd7;
    wdata_v[1] = 8'h3C;
    wr_v[1]    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wr_v[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_v[1]) seen = 1'b1;
    end
    check("abort_perr", int'(perr_v[1]), 1);
    check("abort_no_done", int'(seen), 0);
    exp_q.push_back(8'h00);
    access(1, 1'b0, 4'd7, 8'h00, 4);

    // Reset pulse in the middle of BUSY.
    @(posedge clk); #1;
    addr_v[0]  = 4'd2;
    wdata_v[0] = 8'h77;
    wr_v[0]    = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midreset_done", int'(done_v[0]), 0);
    check("midreset_rdata", int'(rdata_v[0]), 0);
    check("midreset_perr", int'(perr_v[0]), 0);
    wr_v[0] = 1'b0;
    clear_model();
    #3;
    rst = 1'b1;
    exp_q.push_back(8'h00);
    access(0, 1'b0, 4'd3, 8'h00, 2);
    access(0, 1'b1, 4'd2, 8'h77, 2);
    exp_q.push_back(8'h77);
    access(0, 1'b0, 4'd2, 8'h00, 2);
    check("post_reset_perr", int'(perr_v[0]), 0);

    // Back-to-back write/read pairs over every address for LATENCY 1 and 3.
    for (int d = 2; d < 4; d++) begin
      for (int a = 0; a < 16; a++) begin
        rnd = 8'($urandom_range(0, 255));
        access(d, 1'b1, 4'(a), rnd, (d == 2) ? 1 : 3);
        exp_q.push_back(model[d][a]);
        access(d, 1'b0, 4'(a), 8'h00, (d == 2) ? 1 : 3);
      end
      check($sformatf("sweep_perr d%0d", d), int'(perr_v[d]), 0);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
